// File: rtl/tspi_pkg.sv
// Shared constants and types for the TSPI block responder.
package tspi_pkg;

  // Lowest byte address routed to the block read/write window.
  localparam logic [31:0] BLOCK_READWRITE_MIN_OFFSET = 32'h0001_0000;
  localparam int unsigned TSPI_WORDS_PER_BLOCK       = 128;
  localparam int unsigned TSPI_BLK_ADDR_W            = 21;
  localparam int unsigned OBI_AID_W                  = 4;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    WR_STROBE,
    WR_SETTLE,
    WR_PUSH,
    RD_WAIT,
    RD_PRESENT,
    RD_STROBE,
    WAIT_DONE,
    RESP
  } tspi_block_rsp_state_t;

  typedef struct packed {
    logic                 req;
    logic                 we;
    logic [3:0]           be;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [OBI_AID_W-1:0] aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]          rdata;
    logic [OBI_AID_W-1:0] rid;
    logic                 err;
  } sbr_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    sbr_obi_r_t r;
  } sbr_obi_rsp_t;

endpackage

// File: rtl/tspi_block_rsp.sv
// OBI subordinate that turns one block read/write request into a block command
// for the SPI engine and paces the 128-word stream with strobes toward the initiator.
module tspi_block_rsp
  import tspi_pkg::*;
#(
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned WordsPerBlock = TSPI_WORDS_PER_BLOCK
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  sbr_obi_req_t               obi_req_i,
  output sbr_obi_rsp_t               obi_rsp_o,
  input  logic [31:0]                write_data_i,
  output logic                       signal_next_write_data_o,
  output logic [31:0]                read_data_o,
  output logic                       signal_next_read_data_o,
  output logic                       cmd_valid_o,
  input  logic                       cmd_ready_i,
  output logic                       cmd_write_o,
  output logic [TSPI_BLK_ADDR_W-1:0] cmd_blk_addr_o,
  output logic [31:0]                wr_word_o,
  output logic                       wr_word_valid_o,
  input  logic                       wr_word_ready_i,
  input  logic [31:0]                rd_word_i,
  input  logic                       rd_word_valid_i,
  output logic                       rd_word_ready_o,
  input  logic                       eng_done_i,
  input  logic                       eng_err_i
);

  localparam int unsigned SettleW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);
  localparam logic [6:0] LastWord = 7'(WordsPerBlock - 1);

  tspi_block_rsp_state_t state_q, state_d;
  logic [6:0]                 cnt_q, cnt_d;
  logic [SettleW-1:0]         settle_q, settle_d;
  logic                       err_q, err_d;
  logic [OBI_AID_W-1:0]       aid_q, aid_d;
  logic                       we_q, we_d;
  logic [TSPI_BLK_ADDR_W-1:0] blk_addr_q, blk_addr_d;
  logic [31:0]                wr_word_q, wr_word_d;
  logic [31:0]                read_data_q, read_data_d;

  logic        gnt;
  logic [31:0] blk_full;
  logic        out_of_window;
  logic        unused_req_bits;

  assign unused_req_bits = ^{obi_req_i.be, obi_req_i.wdata};

  // Window decode: below the offset, or a block index that needs more than 21 bits.
  assign blk_full      = obi_req_i.addr - BLOCK_READWRITE_MIN_OFFSET;
  assign out_of_window = (obi_req_i.addr < BLOCK_READWRITE_MIN_OFFSET) ||
                         (|blk_full[31:TSPI_BLK_ADDR_W]);

  // Next-state logic; an engine error overrides every handshake of the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    err_d       = err_q;
    aid_d       = aid_q;
    we_d        = we_q;
    blk_addr_d  = blk_addr_q;
    wr_word_d   = wr_word_q;
    read_data_d = read_data_q;
    gnt         = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt = rst_ni & obi_req_i.req;
        if (gnt) begin
          we_d       = obi_req_i.we;
          aid_d      = obi_req_i.aid;
          blk_addr_d = blk_full[TSPI_BLK_ADDR_W-1:0];
          if (out_of_window) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = CMD;
          end
        end
      end
      CMD: begin
        if (cmd_ready_i) state_d = we_q ? WR_STROBE : RD_WAIT;
      end
      WR_STROBE: state_d = WR_SETTLE;
      WR_SETTLE: begin
        if (settle_q == SettleLast) begin
          settle_d  = '0;
          wr_word_d = write_data_i;
          state_d   = WR_PUSH;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      WR_PUSH: begin
        if (wr_word_ready_i) begin
          cnt_d   = cnt_q + 7'd1;
          state_d = (cnt_q == LastWord) ? WAIT_DONE : WR_STROBE;
        end
      end
      RD_WAIT: begin
        if (rd_word_valid_i) begin
          read_data_d = rd_word_i;
          state_d     = RD_PRESENT;
        end
      end
      RD_PRESENT: state_d = RD_STROBE;
      RD_STROBE: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          cnt_d    = cnt_q + 7'd1;
          state_d  = (cnt_q == LastWord) ? WAIT_DONE : RD_WAIT;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      WAIT_DONE: begin
        if (eng_done_i) state_d = RESP;
      end
      RESP: begin
        state_d  = IDLE;
        cnt_d    = '0;
        settle_d = '0;
        err_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // RESP is already answering, so a late error there must not cause a second response.
    if (eng_err_i && (state_q != IDLE) && (state_q != RESP)) begin
      err_d       = 1'b1;
      state_d     = RESP;
      cnt_d       = cnt_q;
      settle_d    = '0;
      wr_word_d   = wr_word_q;
      read_data_d = read_data_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      err_q       <= 1'b0;
      aid_q       <= '0;
      we_q        <= 1'b0;
      blk_addr_q  <= '0;
      wr_word_q   <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      aid_q       <= aid_d;
      we_q        <= we_d;
      blk_addr_q  <= blk_addr_d;
      wr_word_q   <= wr_word_d;
      read_data_q <= read_data_d;
    end
  end

  // Moore outputs; data buses are forced to zero whenever their state is not active.
  assign signal_next_write_data_o = (state_q == WR_STROBE);
  assign signal_next_read_data_o  = (state_q == RD_STROBE);
  assign cmd_valid_o              = (state_q == CMD);
  assign cmd_write_o              = (state_q == CMD) & we_q;
  assign cmd_blk_addr_o           = (state_q == CMD) ? blk_addr_q : '0;
  assign wr_word_valid_o          = (state_q == WR_PUSH);
  assign wr_word_o                = (state_q == WR_PUSH) ? wr_word_q : '0;
  assign rd_word_ready_o          = (state_q == RD_WAIT);
  // read_data_o keeps the last handshaked word for the whole transfer, silent in IDLE.
  assign read_data_o              = (state_q == IDLE) ? '0 : read_data_q;

  assign obi_rsp_o.gnt     = gnt;
  assign obi_rsp_o.rvalid  = (state_q == RESP);
  assign obi_rsp_o.r.rdata = '0;
  assign obi_rsp_o.r.rid   = (state_q == RESP) ? aid_q : '0;
  assign obi_rsp_o.r.err   = (state_q == RESP) & err_q;

endmodule

// File: doc/tspi_block_rsp.md
TSPI_BLOCK_RSP -- requirements
Module: tspi_block_rsp

Interface
REQ-001 SHALL have parameter SettleCycles, default 4: cycles between a word strobe and the word-data sample or update.
REQ-002 SHALL have parameter WordsPerBlock, default 128: 32-bit words per 512-byte block.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port obi_req_i, input, sbr_obi_req_t: OBI subordinate request.
REQ-006 SHALL have port obi_rsp_o, output, sbr_obi_rsp_t: OBI subordinate response.
REQ-007 SHALL have ports write_data_i (input, 32) and signal_next_write_data_o (output, 1): word stream from the initiator for block writes.
REQ-008 SHALL have ports read_data_o (output, 32) and signal_next_read_data_o (output, 1): word stream to the initiator for block reads.
REQ-009 SHALL have ports cmd_valid_o (out, 1), cmd_ready_i (in, 1), cmd_write_o (out, 1) and cmd_blk_addr_o (out, 21): block command to the SPI engine.
REQ-010 SHALL have ports wr_word_o (out, 32), wr_word_valid_o (out, 1) and wr_word_ready_i (in, 1): write words to the engine.
REQ-011 SHALL have ports rd_word_i (in, 32), rd_word_valid_i (in, 1) and rd_word_ready_o (out, 1): read words from the engine.
REQ-012 SHALL have ports eng_done_i (in, 1) and eng_err_i (in, 1): engine completion and error pulses.

Function
REQ-013 SHALL use states IDLE, CMD, WR_STROBE, WR_SETTLE, WR_PUSH, RD_WAIT, RD_PRESENT, RD_STROBE, WAIT_DONE and RESP.
REQ-014 SHALL assert gnt combinationally only in IDLE while req is high, so at most one transaction is outstanding.
REQ-015 SHALL, on a granted request, latch we, aid and blk_addr = addr - BLOCK_READWRITE_MIN_OFFSET, truncated to 21 bits.
REQ-016 SHALL treat addr below BLOCK_READWRITE_MIN_OFFSET, or blk_addr above 21 bits, as out-of-window: go IDLE->RESP, respond with err=1, and start no transfer.
REQ-017 SHALL, in CMD, hold cmd_valid_o high with stable cmd_write_o and cmd_blk_addr_o until cmd_ready_i, then go to WR_STROBE if we=1, else to RD_WAIT.
REQ-018 SHALL, in WR_STROBE, drive signal_next_write_data_o high for exactly one cycle, then go to WR_SETTLE.
REQ-019 SHALL, in WR_SETTLE, count SettleCycles cycles, then sample write_data_i into a word register and go to WR_PUSH.
REQ-020 SHALL, in WR_PUSH, hold wr_word_valid_o high until wr_word_ready_i, then increment the 7-bit word counter.
REQ-021 SHALL, after the WR_PUSH handshake, go to WAIT_DONE if the counter was WordsPerBlock-1, else back to WR_STROBE.
REQ-022 SHALL, in RD_WAIT, assert rd_word_ready_o; on rd_word_valid_i it SHALL register rd_word_i onto read_data_o and go to RD_PRESENT.
REQ-023 SHALL hold read_data_o stable for one cycle in RD_PRESENT, then raise signal_next_read_data_o.
REQ-024 SHALL, in RD_STROBE, keep signal_next_read_data_o high for SettleCycles cycles, then drop it and increment the counter.
REQ-025 SHALL, after RD_STROBE, go to WAIT_DONE on the last word, else back to RD_WAIT.
REQ-026 SHALL hold read_data_o at its value until the next rd_word_valid_i handshake.
REQ-027 SHALL wait in WAIT_DONE for eng_done_i, then go to RESP.
REQ-028 SHALL, in RESP, assert rvalid for one cycle with r.rid = latched aid, r.err = sticky error flag and rdata = 0, then go IDLE and clear the counter and error flag.
REQ-029 SHALL, on eng_err_i in any non-IDLE state, set the sticky error flag and go to RESP next cycle (abort).
REQ-030 SHALL, on abort, deassert all strobes and valids in the following cycle.
REQ-031 SHALL give eng_err_i priority over eng_done_i and over handshakes when they coincide in the same cycle.
REQ-032 SHALL ignore eng_done_i outside WAIT_DONE.
REQ-033 SHALL make the word counter wrap 127->0 naturally; only the last-word compare ends the loop.
REQ-034 SHALL produce strobes with clean rising edges: every strobe is low for at least one cycle between words.

Reset
REQ-035 SHALL, on reset, set state to IDLE and counter, settle counter, error flag, latched aid, latched we, blk_addr and read_data_o to 0.
REQ-036 SHALL drive every output to 0 in reset and in IDLE, except gnt as stated in REQ-014.
REQ-037 SHALL, on reset mid-transfer, drop all strobes and valids the next cycle and issue no rvalid.

Structure
REQ-038 SHALL take BLOCK_READWRITE_MIN_OFFSET, TSPI_WORDS_PER_BLOCK and the state enum tspi_block_rsp_state_t from tspi_pkg.
REQ-039 SHALL take the sbr_obi_req_t/sbr_obi_rsp_t types from the existing packages.
REQ-040 SHALL be a single module with no sub-modules, with all registers built from the common_cells register macros.

Verification
REQ-041 SHALL test a block write: addr = MIN_OFFSET+5, we=1, 128 words 0..127 -> cmd_blk_addr_o=5, 128 strobes, wr_word_o matches, one rvalid with err=0 after eng_done_i.
REQ-042 SHALL test a block read: engine supplies 0xA5000000+i -> read_data_o stable one cycle before each strobe rise, 128 rises, rvalid with err=0.
REQ-043 SHALL test out-of-window: addr = MIN_OFFSET-4 -> gnt, rvalid next cycle with err=1, cmd_valid_o never high.
REQ-044 SHALL test engine error: eng_err_i at word 60 of a write -> strobes stop, rvalid with err=1, the next request accepted normally.
REQ-045 SHALL test back-pressure: cmd_ready_i low 10 cycles and wr_word_ready_i toggling -> signals held stable, no lost or duplicated words.
REQ-046 SHALL test reset mid-read at word 30 -> all outputs 0 next cycle, no rvalid, a fresh read completes correctly.
